// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared status and sequencer encodings for the stopwatch front-end
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    typedef enum logic {
        SEQ_READY    = 1'b0,
        SEQ_WAIT_ACK = 1'b1
    } seq_state_e;

    // 2'b11 is not a state the control FSM should report; treat it as idle.
    function automatic logic [1:0] norm_status(input logic [1:0] st);
        return (st == 2'b11) ? ST_IDLE : st;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, level debouncer and registered press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic [1:0]    vld_q;
    logic          armed_q, armed_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          differ, flip;

    assign differ = (sync2_q != deb_q);
    assign flip   = differ && (cnt_q == CNT_MAX);

    // Presses are only honoured once a genuine released sample has come through
    // the synchronizer since reset, so a button held across reset stays silent.
    always_comb begin
        cnt_d   = '0;
        if (differ && !flip) begin
            cnt_d = cnt_q + CW'(1);
        end
        deb_d   = flip ? ~deb_q : deb_q;
        press_d = flip && !deb_q && armed_q;
        armed_d = armed_q | (vld_q[1] & ~sync2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_cmd_seq.sv
// rtl/stopwatch_cmd_seq.sv - button command sequencer; lap freeze/capture built only with STOPWATCH_LAP_EN
module stopwatch_cmd_seq
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [1:0] status,
    output logic       start,
    output logic       stop,
    output logic       reset,
    output logic       lap_capture,
    output logic       lap_freeze,
    output logic       cmd_err
);

    localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    logic [1:0]    exp_q, exp_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          start_q, start_d, stop_q, stop_d, rst_q, rst_d;
    logic          cap_q, cap_d, frz_q, frz_d, err_q, err_d;
    logic          press_ss, press_lr;
    logic [1:0]    st;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_ss),
        .press_o(press_ss)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lr (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_lr),
        .press_o(press_lr)
    );

    assign st = norm_status(status);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        rst_d   = 1'b0;
        cap_d   = 1'b0;
        frz_d   = frz_q;
        err_d   = 1'b0;
        if (state_q == SEQ_READY) begin
            tmo_d = '0;
            // ss wins a same-cycle tie; the lr event is simply lost.
            if (press_ss) begin
                if (st == ST_RUN) begin
                    stop_d = 1'b1;
                    exp_d  = ST_PAUSE;
                end else begin
                    start_d = 1'b1;
                    exp_d   = ST_RUN;
                end
                state_d = SEQ_WAIT_ACK;
            end else if (press_lr) begin
`ifdef STOPWATCH_LAP_EN
                if (st == ST_RUN) begin
                    frz_d = ~frz_q;
                    cap_d = ~frz_q;
                end else if ((st == ST_PAUSE) && frz_q) begin
                    frz_d = 1'b0;
                end else begin
                    rst_d   = 1'b1;
                    exp_d   = ST_IDLE;
                    frz_d   = 1'b0;
                    state_d = SEQ_WAIT_ACK;
                end
`else
                if (st != ST_RUN) begin
                    rst_d   = 1'b1;
                    exp_d   = ST_IDLE;
                    state_d = SEQ_WAIT_ACK;
                end
`endif
            end
        end else begin
            // The pulse cycle itself is the first cycle counted toward the timeout.
            if (st == exp_q) begin
                state_d = SEQ_READY;
                tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = SEQ_READY;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_READY;
            exp_q   <= ST_IDLE;
            tmo_q   <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rst_q   <= 1'b0;
            cap_q   <= 1'b0;
            frz_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            rst_q   <= rst_d;
            cap_q   <= cap_d;
            frz_q   <= frz_d;
            err_q   <= err_d;
        end
    end

    assign start       = start_q;
    assign stop        = stop_q;
    assign reset       = rst_q;
    assign lap_capture = cap_q;
    assign lap_freeze  = frz_q;
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_stopwatch_cmd_seq.sv
// tb/tb_stopwatch_cmd_seq.sv - self-checking bench for stopwatch_cmd_seq
module tb_stopwatch_cmd_seq;

    localparam int D = 4;
    localparam int T = 8;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, btn_ss, btn_lr;
    logic [1:0] status;
    logic       start, stop, reset, lap_capture, lap_freeze, cmd_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Control FSM model driving status
    bit         fsm_en;
    bit         ignore_start;
    logic [1:0] st_next;

    // Reference model: sliding-window debounce plus rule-level sequencer
    bit [1:0] pipe[2];
    bit [1:0] pv[2];
    bit [D:0] win[2];
    int       wn[2];
    bit       mdeb[2], marm[2], mpress[2];
    bit       m_wait, m_frz;
    logic [1:0] m_exp;
    int       m_deadline;
    logic [5:0] m_out;

    typedef struct {
        logic [1:0] st;
        bit         use_lr;
        logic [4:0] exp_lap;
        bit         frz_lap;
        logic [4:0] exp_nolap;
    } vec_t;
    vec_t tbl[11];

    stopwatch_cmd_seq #(.DEBOUNCE_CYCLES(D), .ACK_TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .status     (status),
        .start      (start),
        .stop       (stop),
        .reset      (reset),
        .lap_capture(lap_capture),
        .lap_freeze (lap_freeze),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            pipe[b] = '0; pv[b] = '0; win[b] = '0; wn[b] = 0;
            mdeb[b] = 1'b0; marm[b] = 1'b0; mpress[b] = 1'b0;
        end
        m_wait = 1'b0; m_frz = 1'b0; m_exp = 2'b00; m_deadline = 0; m_out = '0;
    endtask

    // Level flips once the last D+1 synchronized samples all disagree with it.
    task automatic deb_step(input int b, input bit raw);
        bit s, v, flip;
        s = pipe[b][1];
        v = pv[b][1];
        pipe[b] = {pipe[b][0], raw};
        pv[b]   = {pv[b][0], 1'b1};
        win[b]  = {win[b][D-1:0], s};
        if (wn[b] <= D) wn[b]++;
        flip = (wn[b] == D + 1) && (mdeb[b] ? (win[b] == '0) : (win[b] == '1));
        mpress[b] = flip && !mdeb[b] && marm[b];
        if (flip) mdeb[b] = !mdeb[b];
        if (v && !s) marm[b] = 1'b1;
    endtask

    task automatic model_step(input bit raw_ss, input bit raw_lr, input logic [1:0] st_in, input int n);
        logic [1:0] s;
        bit nstart, nstop, nrst, ncap, nerr;
        s = (st_in == 2'b11) ? 2'b00 : st_in;
        {nstart, nstop, nrst, ncap, nerr} = '0;
        if (m_wait) begin
            if (s == m_exp) m_wait = 1'b0;
            else if (n >= m_deadline) begin nerr = 1'b1; m_wait = 1'b0; end
        end else if (mpress[0]) begin
            if (s == 2'b01) begin nstop = 1'b1; m_exp = 2'b10; end
            else begin nstart = 1'b1; m_exp = 2'b01; end
            m_wait = 1'b1; m_deadline = n + T;
        end else if (mpress[1]) begin
            if (s == 2'b01) begin
                if (LAP_EN) begin ncap = !m_frz; m_frz = !m_frz; end
            end else if (LAP_EN && s == 2'b10 && m_frz) begin
                m_frz = 1'b0;
            end else begin
                nrst = 1'b1; m_exp = 2'b00; m_frz = 1'b0;
                m_wait = 1'b1; m_deadline = n + T;
            end
        end
        m_out = {nstart, nstop, nrst, ncap, m_frz, nerr};
        deb_step(0, raw_ss);
        deb_step(1, raw_lr);
    endtask

    task automatic tick();
        logic [5:0] act;
        @(negedge clk);
        act = {start, stop, reset, lap_capture, lap_freeze, cmd_err};
        if (!rst_n) model_reset();
        check("scoreboard", int'(act), int'(m_out));
        if (rst_n) model_step(btn_ss, btn_lr, status, cyc);
        st_next = status;
        if (start && !ignore_start) st_next = 2'b01;
        else if (stop)              st_next = 2'b10;
        else if (reset)             st_next = 2'b00;
        @(posedge clk);
        #1;
        if (fsm_en) status = st_next;
        cyc++;
    endtask

    // Cycle numbering: inputs changed just before calling are "cycle -1".
    task automatic observe(input int n, output logic [4:0] seen, output int first_cmd, output int first_err, output int n_cmd);
        seen = '0; first_cmd = -1; first_err = -1; n_cmd = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (start || stop || reset || lap_capture) begin
                n_cmd++;
                if (first_cmd < 0) first_cmd = k - 1;
            end
            if (cmd_err && first_err < 0) first_err = k - 1;
            seen = seen | {start, stop, reset, lap_capture, cmd_err};
        end
    endtask

    initial begin
        logic [4:0] seen, seen2, exp_seen;
        int fc, fe, nc, fc2, fe2, nc2;
        bit exp_frz;

        tbl[0]  = '{2'b01, 1'b1, 5'b00010, 1'b1, 5'b00000};
        tbl[1]  = '{2'b01, 1'b1, 5'b00000, 1'b0, 5'b00000};
        tbl[2]  = '{2'b01, 1'b1, 5'b00010, 1'b1, 5'b00000};
        tbl[3]  = '{2'b10, 1'b0, 5'b10001, 1'b1, 5'b10001};
        tbl[4]  = '{2'b10, 1'b1, 5'b00000, 1'b0, 5'b00101};
        tbl[5]  = '{2'b10, 1'b1, 5'b00101, 1'b0, 5'b00101};
        tbl[6]  = '{2'b01, 1'b0, 5'b01001, 1'b0, 5'b01001};
        tbl[7]  = '{2'b11, 1'b0, 5'b10001, 1'b0, 5'b10001};
        tbl[8]  = '{2'b11, 1'b1, 5'b00100, 1'b0, 5'b00100};
        tbl[9]  = '{2'b01, 1'b1, 5'b00010, 1'b1, 5'b00000};
        tbl[10] = '{2'b00, 1'b1, 5'b00100, 1'b0, 5'b00100};

        rst_n = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0; status = 2'b00;
        fsm_en = 1'b0; ignore_start = 1'b0;
        model_reset();
        tick(); tick();
        check("reset_state", int'({start, stop, reset, lap_capture, lap_freeze, cmd_err}), 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Held start/stop button: one start after edge 7, then one stop
        fsm_en = 1'b1; status = 2'b00;
        btn_ss = 1'b1;
        observe(16, seen, fc, fe, nc);
        check("start_latency", fc, 7);
        check("start_single", nc, 1);
        check("start_only", int'(seen), int'(5'b10000));
        check("status_run", int'(status), 1);
        btn_ss = 1'b0;
        observe(10, seen, fc, fe, nc);
        check("release_silent", int'(seen), 0);
        btn_ss = 1'b1;
        observe(16, seen, fc, fe, nc);
        check("stop_latency", fc, 7);
        check("stop_only", int'(seen), int'(5'b01000));
        check("status_pause", int'(status), 2);
        btn_ss = 1'b0;
        observe(10, seen, fc, fe, nc);

        // Bounce shorter than the debounce window
        seen2 = '0;
        for (int k = 0; k < 20; k++) begin
            btn_ss = k[1];
            tick();
            seen2 = seen2 | {start, stop, reset, lap_capture, cmd_err};
        end
        btn_ss = 1'b0;
        observe(12, seen, fc, fe, nc);
        check("bounce_no_cmd", int'(seen | seen2), 0);

        // Table of single presses against a forced status
        fsm_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            status = tbl[i].st;
            tick(); tick();
            if (tbl[i].use_lr) btn_lr = 1'b1; else btn_ss = 1'b1;
            observe(22, seen, fc, fe, nc);
            btn_lr = 1'b0; btn_ss = 1'b0;
            observe(10, seen2, fc2, fe2, nc2);
            exp_seen = LAP_EN ? tbl[i].exp_lap : tbl[i].exp_nolap;
            exp_frz  = LAP_EN ? tbl[i].frz_lap : 1'b0;
            check($sformatf("table%0d_pulses", i), int'(seen | seen2), int'(exp_seen));
            check($sformatf("table%0d_freeze", i), int'(lap_freeze), int'(exp_frz));
        end

        // Simultaneous press from idle: start only
        fsm_en = 1'b1; status = 2'b00;
        tick();
        btn_ss = 1'b1; btn_lr = 1'b1;
        observe(20, seen, fc, fe, nc);
        check("simul_start_only", int'(seen), int'(5'b10000));
        check("simul_latency", fc, 7);
        btn_ss = 1'b0; btn_lr = 1'b0;
        observe(10, seen, fc, fe, nc);

        // Ignored start: lr press during WAIT_ACK dropped, cmd_err 8 cycles after start
        status = 2'b00; ignore_start = 1'b1;
        tick();
        btn_ss = 1'b1;
        seen = '0; fc = -1; fe = -1; nc = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 2) btn_lr = 1'b1;
            if ((start || stop || reset || lap_capture)) begin
                nc++;
                if (fc < 0) fc = k - 1;
            end
            if (cmd_err && fe < 0) fe = k - 1;
            seen = seen | {start, stop, reset, lap_capture, cmd_err};
        end
        check("timeout_start_cycle", fc, 7);
        check("timeout_err_cycle", fe, 15);
        check("timeout_pulses", int'(seen), int'(5'b10001));
        btn_ss = 1'b0; btn_lr = 1'b0; ignore_start = 1'b0;
        observe(10, seen, fc, fe, nc);
        btn_ss = 1'b1;
        observe(16, seen, fc, fe, nc);
        check("retry_start", int'(seen), int'(5'b10000));
        btn_ss = 1'b0;
        observe(10, seen, fc, fe, nc);

        // Reset mid-debounce with button held: silent until re-pressed
        status = 2'b00;
        btn_ss = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick(); tick();
        check("reset_mid_outputs", int'({start, stop, reset, lap_capture, lap_freeze, cmd_err}), 0);
        status = 2'b00;
        rst_n = 1'b1;
        observe(20, seen, fc, fe, nc);
        check("held_through_reset", int'(seen), 0);
        btn_ss = 1'b0;
        observe(10, seen, fc, fe, nc);
        check("release_after_reset", int'(seen), 0);
        btn_ss = 1'b1;
        observe(16, seen, fc, fe, nc);
        check("repress_start", int'(seen), int'(5'b10000));
        check("repress_latency", fc, 7);
        btn_ss = 1'b0;
        observe(10, seen, fc, fe, nc);

        // Randomized buttons and occasional non-acknowledging FSM
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(9, 0) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(9, 0) == 0) btn_lr = ~btn_lr;
            if ($urandom_range(63, 0) == 0) ignore_start = ~ignore_start;
            tick();
        end
        btn_ss = 1'b0; btn_lr = 1'b0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
